// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_if
// Purpose  : Bundles the miss, memory and cache-array signals of one block-fill
//            controller.
// Ports    : master - the fill controller: takes the miss and memory returns,
//                     and drives requests, array writes and busy.
//            slave  - the cache/memory environment around it.
// Signals  : miss_detected, miss_address        lookup miss and its byte address
//            memory_data_valid, memory_data     word returned by main memory
//            fsm_busy                           fill in progress (pipeline stall)
//            mem_req, memory_address            read request to main memory
//            write_data_array, data_word_addr,
//            data_word                          cache data-array write
//            write_tag_array                    tag/valid write pulse
// Revision : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [ADDR_W-1:0] data_word_addr;
  logic [DATA_W-1:0] data_word;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_req, memory_address,
           write_data_array, data_word_addr, data_word, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_req, memory_address,
           write_data_array, data_word_addr, data_word, write_tag_array
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : L1 cache miss handler. On a miss it fetches the aligned block one
//            word per request, writes each returned word into the data array
//            and pulses the tag write together with the last word.
// Ports    : clk    - system clock, rising edge
//            rst_n  - synchronous active-low reset
//            bus    - cache_fill_fsm_if.master (miss in, memory request/return,
//                     data/tag array writes, fsm_busy stall)
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  cache_fill_fsm_if.master  bus
);

  // Block offset bits (byte granularity) and counter geometry.
  localparam int c_idx_w = $clog2(WORDS_PER_BLOCK);
  localparam int c_off   = c_idx_w + 1;
  localparam int c_cnt_w = c_idx_w + 1;

  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WORDS_PER_BLOCK);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WORDS_PER_BLOCK - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [c_cnt_w-1:0]      r_issue_cnt;
  logic [c_cnt_w-1:0]      r_recv_cnt;
  logic [ADDR_W-1:c_off]   r_base_hi;

  logic                    w_busy;
  logic                    w_mem_req;
  logic                    w_write_data;
  logic                    w_write_tag;
  logic [DATA_W-1:0]       w_data_word;

  // The byte offset of the missing access is irrelevant: the whole block is
  // fetched starting at word 0.
  logic                    w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = &{1'b0, bus.miss_address[c_off-1:0]};

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base_hi   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (bus.miss_detected) begin
          r_base_hi   <= bus.miss_address[ADDR_W-1:c_off];
          r_issue_cnt <= '0;
          r_recv_cnt  <= '0;
        end
      end else begin
        // issue_cnt stops at WORDS_PER_BLOCK because mem_req drops there.
        if (w_mem_req) begin
          r_issue_cnt <= r_issue_cnt + c_cnt_one;
        end
        if (bus.memory_data_valid) begin
          r_recv_cnt <= r_recv_cnt + c_cnt_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_mem_req    = 1'b0;
    w_write_data = 1'b0;
    w_write_tag  = 1'b0;
    w_data_word  = '0;
    case (r_state)
      IDLE: begin
        if (bus.miss_detected) begin
          w_next_state = FILL;
        end
      end
      FILL: begin
        w_busy       = 1'b1;
        w_mem_req    = (r_issue_cnt < c_cnt_full);
        w_write_data = bus.memory_data_valid;
        w_data_word  = bus.memory_data;
        // Responses come back in order, so the last word closes the block.
        if (bus.memory_data_valid && (r_recv_cnt == c_cnt_last)) begin
          w_write_tag  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Word addresses are built by concatenation so the index never carries out
  // of the block. Both come from registers and therefore read 0 after reset.
  assign bus.memory_address   = {r_base_hi, r_issue_cnt[c_idx_w-1:0], 1'b0};
  assign bus.data_word_addr   = {r_base_hi, r_recv_cnt[c_idx_w-1:0], 1'b0};
  assign bus.data_word        = w_data_word;
  assign bus.fsm_busy         = w_busy;
  assign bus.mem_req          = w_mem_req;
  assign bus.write_data_array = w_write_data;
  assign bus.write_tag_array  = w_write_tag;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Directed self-checking bench for cache_fill_fsm with an in-order
//            main-memory responder (fixed or per-word latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_fill_fsm #(
    .WORDS_PER_BLOCK(8),
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus
  logic        miss = 1'b0;
  logic [15:0] miss_addr = 16'h0;
  logic        stray_valid = 1'b0;
  logic [15:0] stray_data = 16'h0;
  logic        resp_valid = 1'b0;
  logic [15:0] resp_data = 16'h0;

  assign bus.miss_detected     = miss;
  assign bus.miss_address      = miss_addr;
  assign bus.memory_data_valid = resp_valid | stray_valid;
  assign bus.memory_data       = stray_valid ? stray_data : resp_data;

  // Memory responder: returns data_base + word index, in request order.
  int          lat = 4;
  bit          irr = 1'b0;
  logic [15:0] data_base = 16'h0;
  int          lat_tab [8] = '{2, 7, 3, 5, 2, 6, 4, 7};
  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;
  req_t q[$];
  int   last_due = 0;

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      int d;
      req_t r;
      d = cyc + (irr ? lat_tab[bus.memory_address[3:1]] : lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      r.addr = bus.memory_address;
      r.due  = d;
      q.push_back(r);
    end
  end

  always @(posedge clk) begin
    #1;
    resp_valid = 1'b0;
    resp_data  = 16'h0;
    if (q.size() != 0) begin
      if (q[0].due == cyc) begin
        resp_valid = 1'b1;
        resp_data  = data_base + 16'(q[0].addr[3:1]);
        q.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    miss = 1'b0;
    stray_valid = 1'b1;
    stray_data = 16'hBEEF;
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.fsm_busy); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL reset_wda got %b want 0", bus.write_data_array); end
    checks++; if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL reset_tag got %b want 0", bus.write_tag_array); end
    checks++; if (bus.memory_address !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", bus.memory_address); end
    checks++; if (bus.data_word_addr !== 16'h0) begin errors++; $display("FAIL reset_data_addr got %h want 0000", bus.data_word_addr); end
    checks++; if (bus.data_word !== 16'h0) begin errors++; $display("FAIL reset_data_word got %h want 0000", bus.data_word); end
    tick();
    rst_n = 1'b1;
    stray_valid = 1'b0;
    tick();
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic();
    bit eb, er, ew, et;
    logic [15:0] ra, wa, wd;
    tick();
    irr = 1'b0; lat = 4; data_base = 16'h1000;
    miss = 1'b1; miss_addr = 16'h1236;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) miss = 1'b0;
      @(negedge clk);
      eb = (c <= 12); er = (c <= 8); ew = (c >= 5) && (c <= 12); et = (c == 12);
      ra = 16'h1230 + 16'(2 * (c - 1));
      wa = 16'h1230 + 16'(2 * (c - 5));
      wd = 16'h1000 + 16'(c - 5);
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL basic_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL basic_req c=%0d got %b want %b", c, bus.mem_req, er); end
      if (er) begin
        checks++; if (bus.memory_address !== ra) begin errors++; $display("FAIL basic_req_addr c=%0d got %h want %h", c, bus.memory_address, ra); end
      end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL basic_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      if (ew) begin
        checks++; if (bus.data_word_addr !== wa) begin errors++; $display("FAIL basic_wr_addr c=%0d got %h want %h", c, bus.data_word_addr, wa); end
        checks++; if (bus.data_word !== wd) begin errors++; $display("FAIL basic_wr_data c=%0d got %h want %h", c, bus.data_word, wd); end
      end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL basic_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_upper_block();
    bit eb, er, ew, et;
    logic [15:0] ra, wa, wd;
    int nwr = 0;
    tick();
    irr = 1'b0; lat = 1; data_base = 16'hA000;
    miss = 1'b1; miss_addr = 16'hFFFF;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) miss = 1'b0;
      @(negedge clk);
      eb = (c <= 9); er = (c <= 8); ew = (c >= 2) && (c <= 9); et = (c == 9);
      ra = 16'hFFF0 + 16'(2 * (c - 1));
      wa = 16'hFFF0 + 16'(2 * (c - 2));
      wd = 16'hA000 + 16'(c - 2);
      if (bus.write_data_array === 1'b1) nwr++;
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL upper_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL upper_req c=%0d got %b want %b", c, bus.mem_req, er); end
      if (er) begin
        checks++; if (bus.memory_address !== ra) begin errors++; $display("FAIL upper_req_addr c=%0d got %h want %h", c, bus.memory_address, ra); end
      end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL upper_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      if (ew) begin
        checks++; if (bus.data_word_addr !== wa) begin errors++; $display("FAIL upper_wr_addr c=%0d got %h want %h", c, bus.data_word_addr, wa); end
        checks++; if (bus.data_word !== wd) begin errors++; $display("FAIL upper_wr_data c=%0d got %h want %h", c, bus.data_word, wd); end
      end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL upper_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
    end
    checks++; if (nwr != 8) begin errors++; $display("FAIL upper_write_count got %0d want 8", nwr); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_ignored_inputs();
    bit eb, er, ew, et;
    logic [15:0] ra, wa, wd;
    int nreq = 0;
    tick();
    stray_valid = 1'b1; stray_data = 16'h5A5A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.write_data_array !== 1'b0) begin errors++; $display("FAIL idle_valid_wda c=%0d got %b want 0", c, bus.write_data_array); end
      checks++; if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL idle_valid_busy c=%0d got %b want 0", c, bus.fsm_busy); end
      tick();
    end
    stray_valid = 1'b0;
    irr = 1'b0; lat = 4; data_base = 16'h3000;
    miss = 1'b1; miss_addr = 16'h0540;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1 || c == 4 || c == 13) miss = 1'b0;
      if (c == 3 || c == 12) begin miss = 1'b1; miss_addr = 16'h4000; end
      if (c == 14) begin stray_valid = 1'b1; stray_data = 16'h6B6B; end
      @(negedge clk);
      eb = (c <= 12); er = (c <= 8); ew = (c >= 5) && (c <= 12); et = (c == 12);
      ra = 16'h0540 + 16'(2 * (c - 1));
      wa = 16'h0540 + 16'(2 * (c - 5));
      wd = 16'h3000 + 16'(c - 5);
      if (bus.mem_req === 1'b1) nreq++;
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL ign_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL ign_req c=%0d got %b want %b", c, bus.mem_req, er); end
      if (er) begin
        checks++; if (bus.memory_address !== ra) begin errors++; $display("FAIL ign_req_addr c=%0d got %h want %h", c, bus.memory_address, ra); end
      end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL ign_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      if (ew) begin
        checks++; if (bus.data_word_addr !== wa) begin errors++; $display("FAIL ign_wr_addr c=%0d got %h want %h", c, bus.data_word_addr, wa); end
        checks++; if (bus.data_word !== wd) begin errors++; $display("FAIL ign_wr_data c=%0d got %h want %h", c, bus.data_word, wd); end
      end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL ign_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
    end
    stray_valid = 1'b0;
    checks++; if (nreq != 8) begin errors++; $display("FAIL ign_req_count got %0d want 8", nreq); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_fill();
    bit eb, er, ew, et;
    logic [15:0] ra, wa, wd;
    tick();
    irr = 1'b0; lat = 4; data_base = 16'h2000;
    miss = 1'b1; miss_addr = 16'h0300;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) miss = 1'b0;
      if (c == 8) rst_n = 1'b0;
      if (c == 9) rst_n = 1'b1;
      @(negedge clk);
      eb = (c <= 8); er = (c <= 8); ew = (c >= 5) && (c <= 8); et = 1'b0;
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL rmid_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL rmid_req c=%0d got %b want %b", c, bus.mem_req, er); end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL rmid_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL rmid_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
      if (c == 9) begin
        checks++; if (bus.memory_address !== 16'h0) begin errors++; $display("FAIL rmid_mem_addr got %h want 0000", bus.memory_address); end
        checks++; if (bus.data_word_addr !== 16'h0) begin errors++; $display("FAIL rmid_data_addr got %h want 0000", bus.data_word_addr); end
        checks++; if (bus.data_word !== 16'h0) begin errors++; $display("FAIL rmid_data_word got %h want 0000", bus.data_word); end
      end
    end
    // Fresh fill after the abandoned one.
    tick();
    data_base = 16'h2000;
    miss = 1'b1; miss_addr = 16'h0020;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) miss = 1'b0;
      @(negedge clk);
      eb = (c <= 12); er = (c <= 8); ew = (c >= 5) && (c <= 12); et = (c == 12);
      ra = 16'h0020 + 16'(2 * (c - 1));
      wa = 16'h0020 + 16'(2 * (c - 5));
      wd = 16'h2000 + 16'(c - 5);
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL refill_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL refill_req c=%0d got %b want %b", c, bus.mem_req, er); end
      if (er) begin
        checks++; if (bus.memory_address !== ra) begin errors++; $display("FAIL refill_req_addr c=%0d got %h want %h", c, bus.memory_address, ra); end
      end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL refill_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      if (ew) begin
        checks++; if (bus.data_word_addr !== wa) begin errors++; $display("FAIL refill_wr_addr c=%0d got %h want %h", c, bus.data_word_addr, wa); end
        checks++; if (bus.data_word !== wd) begin errors++; $display("FAIL refill_wr_data c=%0d got %h want %h", c, bus.data_word, wd); end
      end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL refill_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    bit eb, er, ew, et;
    logic [15:0] ra, wa, wd, b;
    int k;
    int ntag = 0;
    tick();
    irr = 1'b0; lat = 4; data_base = 16'h1000;
    miss = 1'b1; miss_addr = 16'h0100;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 12) miss_addr = 16'h0200;
      if (c == 14) miss = 1'b0;
      @(negedge clk);
      // Second fill starts at c=14: relative cycle k restarts there.
      k = (c <= 13) ? c : c - 13;
      b = (c <= 13) ? 16'h0100 : 16'h0200;
      eb = (k <= 12); er = (k <= 8); ew = (k >= 5) && (k <= 12); et = (k == 12);
      ra = b + 16'(2 * (k - 1));
      wa = b + 16'(2 * (k - 5));
      wd = 16'h1000 + 16'(k - 5);
      if (bus.write_tag_array === 1'b1) ntag++;
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL b2b_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL b2b_req c=%0d got %b want %b", c, bus.mem_req, er); end
      if (er) begin
        checks++; if (bus.memory_address !== ra) begin errors++; $display("FAIL b2b_req_addr c=%0d got %h want %h", c, bus.memory_address, ra); end
      end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL b2b_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      if (ew) begin
        checks++; if (bus.data_word_addr !== wa) begin errors++; $display("FAIL b2b_wr_addr c=%0d got %h want %h", c, bus.data_word_addr, wa); end
        checks++; if (bus.data_word !== wd) begin errors++; $display("FAIL b2b_wr_data c=%0d got %h want %h", c, bus.data_word, wd); end
      end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL b2b_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
    end
    checks++; if (ntag != 2) begin errors++; $display("FAIL b2b_tag_count got %0d want 2", ntag); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_irregular_latency();
    bit eb, er, ew, et;
    logic [15:0] ra, wa, wd;
    int n = 0;
    tick();
    irr = 1'b1; data_base = 16'h7000;
    miss = 1'b1; miss_addr = 16'h0A8E;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) miss = 1'b0;
      @(negedge clk);
      // Per-word latencies 2,7,3,5,2,6,4,7 in order give valids on 3,9..15.
      eb = (c <= 15); er = (c <= 8); ew = (c == 3) || ((c >= 9) && (c <= 15)); et = (c == 15);
      ra = 16'h0A80 + 16'(2 * (c - 1));
      wa = 16'h0A80 + 16'(2 * n);
      wd = 16'h7000 + 16'(n);
      checks++; if (bus.fsm_busy !== eb) begin errors++; $display("FAIL irr_busy c=%0d got %b want %b", c, bus.fsm_busy, eb); end
      checks++; if (bus.mem_req !== er) begin errors++; $display("FAIL irr_req c=%0d got %b want %b", c, bus.mem_req, er); end
      if (er) begin
        checks++; if (bus.memory_address !== ra) begin errors++; $display("FAIL irr_req_addr c=%0d got %h want %h", c, bus.memory_address, ra); end
      end
      checks++; if (bus.write_data_array !== ew) begin errors++; $display("FAIL irr_wda c=%0d got %b want %b", c, bus.write_data_array, ew); end
      if (ew) begin
        checks++; if (bus.data_word_addr !== wa) begin errors++; $display("FAIL irr_wr_addr c=%0d got %h want %h", c, bus.data_word_addr, wa); end
        checks++; if (bus.data_word !== wd) begin errors++; $display("FAIL irr_wr_data c=%0d got %h want %h", c, bus.data_word, wd); end
        n++;
      end
      checks++; if (bus.write_tag_array !== et) begin errors++; $display("FAIL irr_tag c=%0d got %b want %b", c, bus.write_tag_array, et); end
    end
    irr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_upper_block();
    test_ignored_inputs();
    test_reset_mid_fill();
    test_back_to_back();
    test_irregular_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
